// File: rtl/s64x7_pkg.sv
// s64x7_pkg: shared constants, types and decode helpers for the s64x7 stack CPU.
//   Opcodes, load/store type codes, reset vector, FSM state type, bus payload
//   struct, and small decode functions used by the core and the LSU.
package s64x7_pkg;

    localparam int unsigned XLEN   = 64;
    localparam int unsigned ADR_W  = 61;
    localparam int unsigned SEL_W  = 8;
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned SLOT_W = 60;
    localparam int unsigned SP_W   = 3;
    localparam int unsigned STK_D  = 8;

    localparam logic [XLEN-1:0] RESET_PC = 64'hE000_0000_0000_0000;
    localparam logic [XLEN-1:0] PC_STEP  = 64'd8;

    // Opcodes
    localparam logic [OPC_W-1:0] OP_END   = 4'd0;
    localparam logic [OPC_W-1:0] OP_LIT8  = 4'd1;
    localparam logic [OPC_W-1:0] OP_LIT32 = 4'd3;
    localparam logic [OPC_W-1:0] OP_STORE = 4'd4;
    localparam logic [OPC_W-1:0] OP_LOAD  = 4'd5;

    // Store types
    localparam logic [3:0] SBM = 4'd0;
    localparam logic [3:0] SHM = 4'd1;
    localparam logic [3:0] SWM = 4'd2;
    localparam logic [3:0] SDM = 4'd3;

    // Load types
    localparam logic [3:0] LBMU = 4'd0;
    localparam logic [3:0] LHMU = 4'd1;
    localparam logic [3:0] LWMU = 4'd2;
    localparam logic [3:0] LDMU = 4'd3;
    localparam logic [3:0] LBMS = 4'd4;
    localparam logic [3:0] LHMS = 4'd5;
    localparam logic [3:0] LWMS = 4'd6;
    localparam logic [3:0] LDMS = 4'd7;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } size_t;

    // Registered bus-side outputs of the core
    typedef struct packed {
        logic [OPC_W-1:0] opc;
        logic             cyc;
        logic             vpa;
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [ADR_W-1:0] adr;
        logic [XLEN-1:0]  dat;
    } bus_t;

    localparam bus_t BUS_RESET = '{
        opc: '0,
        cyc: 1'b1,
        vpa: 1'b1,
        we:  1'b0,
        sel: '1,
        adr: RESET_PC[XLEN-1:3],
        dat: '0
    };

    // State entered when the given opcode reaches the head of the slot register
    function automatic state_t slot_state(input logic [OPC_W-1:0] op);
        state_t s;
        case (op)
            OP_END:            s = S_FETCH;
            OP_STORE, OP_LOAD: s = S_MEM;
            default:           s = S_EXEC;
        endcase
        return s;
    endfunction

    function automatic size_t st_size(input logic [3:0] ty);
        size_t s;
        case (ty)
            SBM:     s = SZ_B;
            SHM:     s = SZ_H;
            SWM:     s = SZ_W;
            SDM:     s = SZ_D;
            default: s = SZ_D;
        endcase
        return s;
    endfunction

    function automatic size_t ld_size(input logic [3:0] ty);
        size_t s;
        case (ty)
            LBMU, LBMS: s = SZ_B;
            LHMU, LHMS: s = SZ_H;
            LWMU, LWMS: s = SZ_W;
            LDMU, LDMS: s = SZ_D;
            default:    s = SZ_D;
        endcase
        return s;
    endfunction

    function automatic logic ld_signed(input logic [3:0] ty);
        logic s;
        case (ty)
            LBMS, LHMS, LWMS: s = 1'b1;
            default:          s = 1'b0;
        endcase
        return s;
    endfunction

    // Byte offset of the lane; address bits below the access size are dropped
    function automatic logic [2:0] lane_off(input size_t sz, input logic [2:0] a);
        logic [2:0] o;
        case (sz)
            SZ_B:    o = a;
            SZ_H:    o = {a[2:1], 1'b0};
            SZ_W:    o = {a[2], 2'b00};
            default: o = 3'd0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/s64x7_lsu.sv
// s64x7_lsu: combinational lane steering for the s64x7 core.
//   Request path: i_req_lane/i_req_type/i_req_load/i_req_data -> o_sel_c, o_wdata_c
//   Load path:    i_ld_lane/i_ld_type/i_ld_rdata              -> o_ldata_c
module s64x7_lsu
    import s64x7_pkg::*;
(
    input  logic [2:0]       i_req_lane,
    input  logic [3:0]       i_req_type,
    input  logic             i_req_load,
    input  logic [XLEN-1:0]  i_req_data,
    input  logic [2:0]       i_ld_lane,
    input  logic [3:0]       i_ld_type,
    input  logic [XLEN-1:0]  i_ld_rdata,
    output logic [SEL_W-1:0] o_sel_c,
    output logic [XLEN-1:0]  o_wdata_c,
    output logic [XLEN-1:0]  o_ldata_c
);

    size_t      w_req_sz;
    logic [2:0] w_req_off;
    size_t      w_ld_sz;
    logic [2:0] w_ld_off;
    logic       w_ld_sgn;
    logic [XLEN-1:0] w_ld_sh;

    // Byte enables and lane-replicated store data for the upcoming request
    always_comb begin : req_path
        w_req_sz  = i_req_load ? ld_size(i_req_type) : st_size(i_req_type);
        w_req_off = lane_off(w_req_sz, i_req_lane);
        o_sel_c   = '0;
        o_wdata_c = '0;
        case (w_req_sz)
            SZ_B: begin
                o_sel_c   = SEL_W'(8'h01) << w_req_off;
                o_wdata_c = {8{i_req_data[7:0]}};
            end
            SZ_H: begin
                o_sel_c   = SEL_W'(8'h03) << w_req_off;
                o_wdata_c = {4{i_req_data[15:0]}};
            end
            SZ_W: begin
                o_sel_c   = SEL_W'(8'h0F) << w_req_off;
                o_wdata_c = {2{i_req_data[31:0]}};
            end
            default: begin
                o_sel_c   = '1;
                o_wdata_c = i_req_data;
            end
        endcase
    end

    // Extract the addressed lane from read data and extend to 64 bits
    always_comb begin : ld_path
        w_ld_sz   = ld_size(i_ld_type);
        w_ld_off  = lane_off(w_ld_sz, i_ld_lane);
        w_ld_sgn  = ld_signed(i_ld_type);
        w_ld_sh   = i_ld_rdata >> {w_ld_off, 3'b000};
        o_ldata_c = '0;
        case (w_ld_sz)
            SZ_B:    o_ldata_c = {{56{w_ld_sgn & w_ld_sh[7]}},  w_ld_sh[7:0]};
            SZ_H:    o_ldata_c = {{48{w_ld_sgn & w_ld_sh[15]}}, w_ld_sh[15:0]};
            SZ_W:    o_ldata_c = {{32{w_ld_sgn & w_ld_sh[31]}}, w_ld_sh[31:0]};
            default: o_ldata_c = w_ld_sh;
        endcase
    end

endmodule

// File: rtl/s64x7.sv
// s64x7: 64-bit stack-machine CPU core with a single Wishbone-style master.
//   clk_i, reset_i (sync, active-low), ack_i, dat_i[63:0] in;
//   opc_o[3:0], adr_o[60:0], cyc_o, stb_o, sel_o[7:0], we_o, vpa_o, dat_o[63:0] out.
//   All outputs are registered; the next-cycle bus view is computed from the
//   next architectural state so that no output depends combinationally on inputs.
module s64x7
    import s64x7_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             ack_i,
    input  logic [XLEN-1:0]  dat_i,
    output logic [OPC_W-1:0] opc_o,
    output logic [ADR_W-1:0] adr_o,
    output logic             cyc_o,
    output logic             stb_o,
    output logic [SEL_W-1:0] sel_o,
    output logic             we_o,
    output logic             vpa_o,
    output logic [XLEN-1:0]  dat_o
);

    state_t            r_state, w_nxt_state;
    logic [XLEN-1:0]   r_pc, w_nxt_pc;
    logic [SLOT_W-1:0] r_opc, w_nxt_opc;
    logic [XLEN-1:0]   r_opr, w_nxt_opr;
    logic [SP_W-1:0]   r_sp, w_nxt_sp;
    logic [XLEN-1:0]   r_stk [STK_D];
    bus_t              r_bus, w_nxt_bus;

    logic [OPC_W-1:0]  w_op, w_nxt_op;
    logic [SP_W-1:0]   w_sp_p1, w_sp_m1, w_sp_m2, w_sp_m3;
    logic [XLEN-1:0]   w_t, w_n, w_n2, w_n3;
    logic              w_step, w_push, w_pop2, w_ld_wr;
    logic [XLEN-1:0]   w_push_val;
    logic [XLEN-1:0]   w_nxt_t, w_nxt_n;
    logic [SEL_W-1:0]  w_sel;
    logic [XLEN-1:0]   w_wdata, w_ldata;

    assign w_op     = r_opc[SLOT_W-1 -: OPC_W];
    assign w_nxt_op = w_nxt_opc[SLOT_W-1 -: OPC_W];
    assign w_sp_p1  = r_sp + SP_W'(1);
    assign w_sp_m1  = r_sp - SP_W'(1);
    assign w_sp_m2  = r_sp - SP_W'(2);
    assign w_sp_m3  = r_sp - SP_W'(3);
    assign w_t      = r_stk[r_sp];
    assign w_n      = r_stk[w_sp_m1];
    assign w_n2     = r_stk[w_sp_m2];
    assign w_n3     = r_stk[w_sp_m3];

    s64x7_lsu u_lsu (
        .i_req_lane (w_nxt_t[2:0]),
        .i_req_type (w_nxt_opr[3:0]),
        .i_req_load (w_nxt_op == OP_LOAD),
        .i_req_data (w_nxt_n),
        .i_ld_lane  (w_t[2:0]),
        .i_ld_type  (r_opr[3:0]),
        .i_ld_rdata (dat_i),
        .o_sel_c    (w_sel),
        .o_wdata_c  (w_wdata),
        .o_ldata_c  (w_ldata)
    );

    // Next state, packet registers and stack actions
    always_comb begin : fsm_next
        w_nxt_state = r_state;
        w_nxt_pc    = r_pc;
        w_nxt_opc   = r_opc;
        w_nxt_opr   = r_opr;
        w_step      = 1'b0;
        w_push      = 1'b0;
        w_push_val  = '0;
        w_pop2      = 1'b0;
        w_ld_wr     = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (ack_i) begin
                    w_step    = 1'b1;
                    w_nxt_opc = dat_i[SLOT_W-1:0];
                    w_nxt_opr = dat_i;
                    w_nxt_pc  = r_pc + PC_STEP;
                end
            end
            S_EXEC: begin
                w_step    = 1'b1;
                w_nxt_opc = r_opc << OPC_W;
                case (w_op)
                    OP_LIT8: begin
                        w_push     = 1'b1;
                        w_push_val = XLEN'(r_opr[7:0]);
                        w_nxt_opr  = r_opr >> 8;
                    end
                    OP_LIT32: begin
                        w_push     = 1'b1;
                        w_push_val = XLEN'(r_opr[31:0]);
                        w_nxt_opr  = r_opr >> 32;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (ack_i) begin
                    w_step    = 1'b1;
                    w_nxt_opc = r_opc << OPC_W;
                    w_nxt_opr = r_opr >> 4;
                    if (w_op == OP_STORE) begin
                        w_pop2 = 1'b1;
                    end else begin
                        w_ld_wr = 1'b1;
                    end
                end
            end
            default: w_nxt_state = S_FETCH;
        endcase
        // A zero head slot (end marker or exhausted packet) goes straight to fetch
        if (w_step) begin
            w_nxt_state = slot_state(w_nxt_op);
        end
    end

    // Next stack pointer and the T/N values visible to the next cycle
    always_comb begin : stack_next
        w_nxt_sp = r_sp;
        w_nxt_t  = w_t;
        w_nxt_n  = w_n;
        if (w_push) begin
            w_nxt_sp = w_sp_p1;
            w_nxt_t  = w_push_val;
            w_nxt_n  = w_t;
        end else if (w_pop2) begin
            w_nxt_sp = w_sp_m2;
            w_nxt_t  = w_n2;
            w_nxt_n  = w_n3;
        end else if (w_ld_wr) begin
            w_nxt_t  = w_ldata;
        end
    end

    // Bus view for the next cycle; idle cycles keep the last address
    always_comb begin : bus_next
        w_nxt_bus     = '0;
        w_nxt_bus.adr = r_bus.adr;
        case (w_nxt_state)
            S_FETCH: begin
                w_nxt_bus.cyc = 1'b1;
                w_nxt_bus.vpa = 1'b1;
                w_nxt_bus.sel = '1;
                w_nxt_bus.adr = w_nxt_pc[XLEN-1:3];
            end
            S_MEM: begin
                w_nxt_bus.opc = w_nxt_op;
                w_nxt_bus.cyc = 1'b1;
                w_nxt_bus.we  = (w_nxt_op == OP_STORE);
                w_nxt_bus.sel = w_sel;
                w_nxt_bus.adr = w_nxt_t[XLEN-1:3];
                w_nxt_bus.dat = (w_nxt_op == OP_STORE) ? w_wdata : '0;
            end
            default: begin
                w_nxt_bus.opc = w_nxt_op;
            end
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            r_state <= S_FETCH;
            r_pc    <= RESET_PC;
            r_opc   <= '0;
            r_opr   <= '0;
            r_sp    <= '0;
            r_bus   <= BUS_RESET;
        end else begin
            r_state <= w_nxt_state;
            r_pc    <= w_nxt_pc;
            r_opc   <= w_nxt_opc;
            r_opr   <= w_nxt_opr;
            r_sp    <= w_nxt_sp;
            r_bus   <= w_nxt_bus;
        end
    end

    // Stack storage; contents are don't-care after reset
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            if (w_push) begin
                r_stk[w_sp_p1] <= w_push_val;
            end else if (w_ld_wr) begin
                r_stk[r_sp] <= w_ldata;
            end
        end
    end

    assign opc_o = r_bus.opc;
    assign adr_o = r_bus.adr;
    assign cyc_o = r_bus.cyc;
    assign stb_o = r_bus.cyc;
    assign sel_o = r_bus.sel;
    assign we_o  = r_bus.we;
    assign vpa_o = r_bus.vpa;
    assign dat_o = r_bus.dat;

endmodule

// File: tb/tb_s64x7.sv
// tb_s64x7: directed scoreboard bench for s64x7. Expected bus views are queued
// as stimulus is driven and compared one per clock, #1 after the rising edge.
module tb_s64x7;
    import s64x7_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ack;
    logic [63:0] dat_in;
    logic [3:0]  opc_o;
    logic [60:0] adr_o;
    logic        cyc_o, stb_o, we_o, vpa_o;
    logic [7:0]  sel_o;
    logic [63:0] dat_o;

    always #5 clk = ~clk;

    s64x7 dut (
        .clk_i   (clk),
        .reset_i (reset_n),
        .ack_i   (ack),
        .dat_i   (dat_in),
        .opc_o   (opc_o),
        .adr_o   (adr_o),
        .cyc_o   (cyc_o),
        .stb_o   (stb_o),
        .sel_o   (sel_o),
        .we_o    (we_o),
        .vpa_o   (vpa_o),
        .dat_o   (dat_o)
    );

    bus_t        exp_q[$];
    string       tag_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] pc       = 64'hE000_0000_0000_0000;
    logic [60:0] last_adr = '0;

    task automatic push_fetch(input string tag);
        bus_t e;
        e = '0;
        e.cyc = 1'b1;
        e.vpa = 1'b1;
        e.sel = 8'hFF;
        e.adr = pc[63:3];
        last_adr = e.adr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic push_exec(input logic [3:0] op, input string tag);
        bus_t e;
        e = '0;
        e.opc = op;
        e.adr = last_adr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic push_mem(input logic [3:0] op, input logic we, input logic [63:0] a,
                            input logic [7:0] sel, input logic [63:0] dat, input string tag);
        bus_t e;
        e = '0;
        e.opc = op;
        e.cyc = 1'b1;
        e.we  = we;
        e.sel = sel;
        e.adr = a[63:3];
        e.dat = dat;
        last_adr = e.adr;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Advance one clock and compare the DUT bus view with the oldest expectation
    task automatic check_cycle();
        bus_t  e, o;
        string t;
        @(posedge clk);
        #1;
        o.opc = opc_o;
        o.cyc = (cyc_o === stb_o) ? cyc_o : 1'bx;
        o.vpa = vpa_o;
        o.we  = we_o;
        o.sel = sel_o;
        o.adr = adr_o;
        o.dat = dat_o;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed opc=%h cyc=%b, nothing expected", o.opc, o.cyc);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (o === e) else begin
                n_fail++;
                $error("FAIL %s: observed opc=%h cyc=%b vpa=%b we=%b sel=%h adr=%h dat=%h expected opc=%h cyc=%b vpa=%b we=%b sel=%h adr=%h dat=%h",
                       t, o.opc, o.cyc, o.vpa, o.we, o.sel, o.adr, o.dat,
                       e.opc, e.cyc, e.vpa, e.we, e.sel, e.adr, e.dat);
            end
        end
    endtask

    // LIT8 0x41, LIT32 addr, STORE type; hold stalls ack on fetch and store
    task automatic run_store(input logic [3:0] ty, input logic [31:0] a, input logic [7:0] sel,
                             input logic [63:0] dat, input int hold, input string tag);
        ack = 1'b0;
        dat_in = 64'hDEAD_BEEF_DEAD_BEEF;
        for (int i = 0; i < hold; i++) begin
            push_fetch({tag, "_fetch_hold"});
            check_cycle();
        end
        ack = 1'b1;
        dat_in = {20'h41340, ty, a, 8'h41};
        push_exec(4'd1, {tag, "_lit8"});
        check_cycle();
        pc = pc + 64'd8;
        dat_in = '0;
        push_exec(4'd3, {tag, "_lit32"});
        check_cycle();
        push_mem(4'd4, 1'b1, {32'd0, a}, sel, dat, {tag, "_store"});
        check_cycle();
        ack = 1'b0;
        for (int i = 0; i < hold; i++) begin
            push_mem(4'd4, 1'b1, {32'd0, a}, sel, dat, {tag, "_store_hold"});
            check_cycle();
        end
        ack = 1'b1;
        push_fetch({tag, "_next_fetch"});
        check_cycle();
    endtask

    // LIT32 addr, LOAD type; then LIT32 11111110, SDM to expose the loaded value
    task automatic run_load(input logic [3:0] ty, input logic [31:0] a, input logic [63:0] rd,
                            input logic [7:0] sel, input logic [63:0] res, input int hold,
                            input string tag);
        ack = 1'b0;
        dat_in = 64'h0123_4567_89AB_CDEF;
        for (int i = 0; i < hold; i++) begin
            push_fetch({tag, "_fetch_hold"});
            check_cycle();
        end
        ack = 1'b1;
        dat_in = {28'h3350000, ty, a};
        push_exec(4'd3, {tag, "_lit32"});
        check_cycle();
        pc = pc + 64'd8;
        dat_in = '0;
        push_mem(4'd5, 1'b0, {32'd0, a}, sel, 64'd0, {tag, "_load"});
        check_cycle();
        ack = 1'b0;
        dat_in = ~rd;
        for (int i = 0; i < hold; i++) begin
            push_mem(4'd5, 1'b0, {32'd0, a}, sel, 64'd0, {tag, "_load_hold"});
            check_cycle();
        end
        ack = 1'b1;
        dat_in = rd;
        push_fetch({tag, "_fetch2"});
        check_cycle();
        dat_in = 64'h3340_0003_1111_1110;
        push_exec(4'd3, {tag, "_lit32b"});
        check_cycle();
        pc = pc + 64'd8;
        dat_in = '0;
        push_mem(4'd4, 1'b1, 64'h1111_1110, 8'hFF, res, {tag, "_result"});
        check_cycle();
        push_fetch({tag, "_fetch3"});
        check_cycle();
    endtask

    initial begin
        reset_n = 1'b0;
        ack     = 1'b1;
        dat_in  = 64'h1300_0000_0000_0000;

        // Reset: shows the reset fetch and ignores ack
        push_fetch("reset");
        check_cycle();
        push_fetch("reset_ack_ignored");
        check_cycle();
        reset_n = 1'b1;

        // Store types
        run_store(SBM, 32'h1111_1111, 8'h02, 64'h4141_4141_4141_4141, 0, "sbm");
        run_store(SHM, 32'h2222_2220, 8'h03, 64'h0041_0041_0041_0041, 0, "shm");
        run_store(SWM, 32'h3333_3334, 8'hF0, 64'h0000_0041_0000_0041, 0, "swm");
        run_store(SDM, 32'h4444_4448, 8'hFF, 64'h0000_0000_0000_0041, 0, "sdm");

        // Load types
        run_load(LBMU, 32'h5555_5555, 64'h0000_8100_0000_0000, 8'h20,
                 64'h0000_0000_0000_0081, 0, "lbmu");
        run_load(LBMS, 32'h5555_5555, 64'h0000_8100_0000_0000, 8'h20,
                 64'hFFFF_FFFF_FFFF_FF81, 2, "lbms_hold");
        run_load(LHMS, 32'h5555_5552, 64'h0000_0000_8100_0000, 8'h0C,
                 64'hFFFF_FFFF_FFFF_8100, 0, "lhms");
        run_load(LWMS, 32'h5555_5554, 64'h8100_0000_0000_0000, 8'hF0,
                 64'hFFFF_FFFF_8100_0000, 0, "lwms");
        run_load(LWMU, 32'h5555_5554, 64'h8100_0000_0000_0000, 8'hF0,
                 64'h0000_0000_8100_0000, 0, "lwmu");
        run_load(4'hC, 32'h5555_5555, 64'h8123_4567_89AB_CDEF, 8'hFF,
                 64'h8123_4567_89AB_CDEF, 0, "ld_unused_type");

        // Stalled fetch and store
        run_store(SBM, 32'h6666_6667, 8'h80, 64'h4141_4141_4141_4141, 3, "sbm_hold");

        // Empty packet: refetch with no execute cycle
        ack = 1'b1;
        dat_in = 64'h0;
        pc = pc + 64'd8;
        push_fetch("empty_packet");
        check_cycle();

        // Fifteen NOP slots, then fetch
        dat_in = 64'h0222_2222_2222_2222;
        for (int i = 0; i < 15; i++) begin
            push_exec(4'd2, "nop_slot");
            check_cycle();
            dat_in = '0;
        end
        pc = pc + 64'd8;
        push_fetch("after_slot15");
        check_cycle();

        // Reset during a store bus cycle aborts it
        dat_in = {20'h41340, SBM, 32'h1111_1111, 8'h41};
        push_exec(4'd1, "abort_lit8");
        check_cycle();
        pc = pc + 64'd8;
        dat_in = '0;
        push_exec(4'd3, "abort_lit32");
        check_cycle();
        push_mem(4'd4, 1'b1, 64'h1111_1111, 8'h02, 64'h4141_4141_4141_4141, "abort_store");
        check_cycle();
        reset_n = 1'b0;
        pc = 64'hE000_0000_0000_0000;
        push_fetch("mid_cycle_reset");
        check_cycle();
        reset_n = 1'b1;
        run_store(SWM, 32'h7777_7770, 8'h0F, 64'h0000_0041_0000_0041, 0, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
